// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the memory-access stage.
//   - byte_num access-size codes (BN_*)
//   - write-back select codes (WB_*)
//   - lsu_state_e: FSM states of mem_lsu
//   - access_size_e / size_of(): collapses byte_num to an access width
package mem_pkg;

    localparam logic [2:0] BN_B  = 3'b000;
    localparam logic [2:0] BN_H  = 3'b001;
    localparam logic [2:0] BN_W  = 3'b010;
    localparam logic [2:0] BN_BU = 3'b100;
    localparam logic [2:0] BN_HU = 3'b101;

    localparam logic [1:0] WB_PC4 = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_MEM = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } access_size_e;

    // Unlisted byte_num codes fall back to a full word access.
    function automatic access_size_e size_of(input logic [2:0] byte_num);
        case (byte_num)
            BN_B, BN_BU: size_of = SZ_B;
            BN_H, BN_HU: size_of = SZ_H;
            default:     size_of = SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the memory-access stage.
//   addr_lo    in  2   low address bits (byte offset within the word)
//   byte_num   in  3   access size / signedness code
//   is_store   in  1   1 = store, 0 = load
//   store_data in  32  raw store data
//   rdata      in  32  word returned by memory
//   wdata      out 32  lane-replicated store data
//   bmask      out 4   byte-lane enables (all lanes for loads)
//   load_data  out 32  aligned, sign/zero-extended load result
//   misaligned out 1   access crosses its natural alignment
module lsu_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  byte_num,
    input  logic        is_store,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  bmask,
    output logic [31:0] load_data,
    output logic        misaligned
);

    access_size_e size;
    logic [31:0]  shifted;
    logic         zero_ext;

    assign size     = size_of(byte_num);
    assign shifted  = rdata >> {addr_lo, 3'b000};
    // BU/HU are the only codes with bit 2 set that map to B/H sizes.
    assign zero_ext = byte_num[2];

    always_comb begin
        wdata      = store_data;
        bmask      = 4'b1111;
        load_data  = shifted;
        misaligned = 1'b0;
        case (size)
            SZ_B: begin
                wdata     = {4{store_data[7:0]}};
                bmask     = is_store ? (4'b0001 << addr_lo) : 4'b1111;
                load_data = zero_ext ? {24'b0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                wdata      = {2{store_data[15:0]}};
                bmask      = is_store ? (4'b0011 << addr_lo) : 4'b1111;
                load_data  = zero_ext ? {16'b0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
                misaligned = addr_lo[0];
            end
            default: begin
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: memory-access pipeline stage between EX/MEM and MEM/WB.
//   i_clk, i_reset (async, active-low)
//   EX/MEM in : i_PC, i_instr, i_alu_data, i_dataR2, i_pc_plus_four,
//               i_rd_wren, i_mem_wren, i_insn_vld, i_wb_sel, i_byte_num
//   dmem bus  : o_dmem_req/we/addr/wdata/bmask out, i_dmem_ack/rdata in
//   o_stall   : holds EX/MEM and earlier stages while memory is busy
//   MEM/WB out: o_PC, o_instr, o_wb_data, o_rd_addr, o_rd_wren,
//               o_insn_vld, o_misaligned, o_bus_err (all registered)
module mem_lsu
    import mem_pkg::*;
#(
    parameter int P_TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_PC,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_alu_data,
    input  logic [31:0] i_dataR2,
    input  logic [31:0] i_pc_plus_four,
    input  logic        i_rd_wren,
    input  logic        i_mem_wren,
    input  logic        i_insn_vld,
    input  logic [1:0]  i_wb_sel,
    input  logic [2:0]  i_byte_num,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_bmask,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_stall,
    output logic [31:0] o_PC,
    output logic [31:0] o_instr,
    output logic [31:0] o_wb_data,
    output logic [4:0]  o_rd_addr,
    output logic        o_rd_wren,
    output logic        o_insn_vld,
    output logic        o_misaligned,
    output logic        o_bus_err
);

    localparam int             CW         = $clog2(P_TIMEOUT) + 1;
    localparam logic [CW-1:0]  CNT_MAX    = CW'(P_TIMEOUT - 1);
    // The request cycle spent in IDLE counts as the first wait cycle, so
    // the WAIT counter (cleared on entry) expires one step earlier.
    localparam logic [CW-1:0]  CNT_EXPIRE = CW'((P_TIMEOUT > 1) ? P_TIMEOUT - 2 : 0);

    lsu_state_e    state_reg;
    logic [CW-1:0] wait_cnt_reg;

    logic        mop;
    logic        misaligned;
    logic        timeout_expiring;
    logic [31:0] load_data;
    logic [31:0] wb_data_next;

    assign mop = i_insn_vld & (i_mem_wren | (i_wb_sel == WB_MEM));

    lsu_align u_align (
        .addr_lo    (i_alu_data[1:0]),
        .byte_num   (i_byte_num),
        .is_store   (i_mem_wren),
        .store_data (i_dataR2),
        .rdata      (i_dmem_rdata),
        .wdata      (o_dmem_wdata),
        .bmask      (o_dmem_bmask),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    // Gating with i_reset drops the request as soon as reset asserts,
    // without waiting for the state register to settle.
    assign o_dmem_req  = i_reset & ((state_reg == WAIT) | (mop & ~misaligned));
    assign o_dmem_we   = o_dmem_req & i_mem_wren;
    assign o_dmem_addr = {i_alu_data[31:2], 2'b00};

    assign timeout_expiring = o_dmem_req & ~i_dmem_ack &
                              ((state_reg == IDLE) ? (P_TIMEOUT == 1)
                                                   : (wait_cnt_reg == CNT_EXPIRE));

    assign o_stall = o_dmem_req & ~i_dmem_ack & ~timeout_expiring;

    always_comb begin
        case (i_wb_sel)
            WB_PC4:  wb_data_next = i_pc_plus_four;
            WB_MEM:  wb_data_next = load_data;
            default: wb_data_next = i_alu_data;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (o_dmem_req && !i_dmem_ack && !timeout_expiring) begin
                        state_reg    <= WAIT;
                        wait_cnt_reg <= '0;
                    end
                end
                WAIT: begin
                    if (i_dmem_ack || timeout_expiring) begin
                        state_reg <= IDLE;
                    end else if (wait_cnt_reg != CNT_MAX) begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_PC         <= '0;
            o_instr      <= '0;
            o_wb_data    <= '0;
            o_rd_addr    <= '0;
            o_rd_wren    <= 1'b0;
            o_insn_vld   <= 1'b0;
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
        end else if (o_stall) begin
            // Bubble into WB while the access is outstanding.
            o_PC         <= '0;
            o_instr      <= '0;
            o_wb_data    <= '0;
            o_rd_addr    <= '0;
            o_rd_wren    <= 1'b0;
            o_insn_vld   <= 1'b0;
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
        end else begin
            o_PC         <= i_PC;
            o_instr      <= i_instr;
            o_wb_data    <= wb_data_next;
            o_rd_addr    <= i_instr[11:7];
            o_rd_wren    <= i_rd_wren & ~(mop & misaligned) & ~timeout_expiring;
            o_insn_vld   <= i_insn_vld;
            o_misaligned <= mop & misaligned;
            o_bus_err    <= timeout_expiring;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

    localparam int P = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc, instr, alu, r2, pc4;
    logic        rd_wren, mem_wren, insn_vld;
    logic [1:0]  wb_sel;
    logic [2:0]  byte_num;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_bmask;
    logic        stall;
    logic [31:0] o_pc, o_instr, o_wb_data;
    logic [4:0]  o_rd_addr;
    logic        o_rd_wren, o_insn_vld, o_mis, o_berr;

    int n_asserts = 0;
    int n_fail    = 0;
    int n_txn     = 0;

    mem_lsu #(.P_TIMEOUT(P)) dut (
        .i_clk          (clk),
        .i_reset        (rst_n),
        .i_PC           (pc),
        .i_instr        (instr),
        .i_alu_data     (alu),
        .i_dataR2       (r2),
        .i_pc_plus_four (pc4),
        .i_rd_wren      (rd_wren),
        .i_mem_wren     (mem_wren),
        .i_insn_vld     (insn_vld),
        .i_wb_sel       (wb_sel),
        .i_byte_num     (byte_num),
        .o_dmem_req     (dmem_req),
        .o_dmem_we      (dmem_we),
        .o_dmem_addr    (dmem_addr),
        .o_dmem_wdata   (dmem_wdata),
        .o_dmem_bmask   (dmem_bmask),
        .i_dmem_ack     (dmem_ack),
        .i_dmem_rdata   (dmem_rdata),
        .o_stall        (stall),
        .o_PC           (o_pc),
        .o_instr        (o_instr),
        .o_wb_data      (o_wb_data),
        .o_rd_addr      (o_rd_addr),
        .o_rd_wren      (o_rd_wren),
        .o_insn_vld     (o_insn_vld),
        .o_misaligned   (o_mis),
        .o_bus_err      (o_berr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Access width in bytes for a byte_num code.
    function automatic int model_size(input logic [2:0] bn);
        case (bn)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    // Load result built from individual bytes of the returned word.
    function automatic logic [31:0] model_load(input logic [31:0] w, input int off,
                                               input logic [2:0] bn);
        int     sz;
        longint v;
        sz = model_size(bn);
        if (sz == 4) return w;
        if (off + sz > 4) return 32'h0;
        if (sz == 1) begin
            v = longint'(w[8*off +: 8]);
            if (bn == 3'b000 && v > 127) v = v - 256;
        end else begin
            v = longint'(w[8*(off+1) +: 8]) * 256 + longint'(w[8*off +: 8]);
            if (bn == 3'b001 && v > 32767) v = v - 65536;
        end
        return v[31:0];
    endfunction

    function automatic logic [3:0] model_bmask(input logic store, input int off, input int sz);
        int m;
        if (!store || sz == 4) return 4'hF;
        m = ((1 << sz) - 1) << off;
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] d, input int sz);
        if (sz == 1) return {24'b0, d[7:0]} * 32'h0101_0101;
        if (sz == 2) return {16'b0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    // One instruction through MEM. ack_delay < 0 means memory never answers.
    task automatic run_insn(input logic [31:0] t_pc, input logic [31:0] t_instr,
                            input logic [31:0] t_alu, input logic [31:0] t_r2,
                            input logic t_rdw, input logic t_memw, input logic t_vld,
                            input logic [1:0] t_sel, input logic [2:0] t_bn,
                            input int ack_delay, input logic [31:0] t_rdata);
        int          sz, off, last;
        logic        mop, mis, exp_req, tmo, ack_now;
        logic [31:0] last_rdata, exp_wb;
        sz      = model_size(t_bn);
        off     = int'(t_alu[1:0]);
        mop     = t_vld && (t_memw || t_sel == 2'b10);
        mis     = (off % sz) != 0;
        exp_req = mop && !mis;
        tmo     = exp_req && (ack_delay < 0 || ack_delay >= P);
        last    = !exp_req ? 0 : (tmo ? P - 1 : ack_delay);
        last_rdata = 32'h0;

        @(negedge clk);
        pc = t_pc; instr = t_instr; alu = t_alu; r2 = t_r2; pc4 = t_pc + 32'd4;
        rd_wren = t_rdw; mem_wren = t_memw; insn_vld = t_vld;
        wb_sel = t_sel; byte_num = t_bn;

        for (int c = 0; c <= last; c++) begin
            ack_now    = exp_req && !tmo && (c == ack_delay);
            // Stray acks while nothing is requested must be ignored.
            dmem_ack   = ack_now || (!exp_req && $urandom_range(0, 2) == 0);
            dmem_rdata = ack_now ? t_rdata : $urandom();
            last_rdata = dmem_rdata;
            #1;
            check("req", 32'(dmem_req), 32'(exp_req));
            if (exp_req) begin
                check("addr", dmem_addr, {t_alu[31:2], 2'b00});
                check("we", 32'(dmem_we), 32'(t_memw));
                check("bmask", 32'(dmem_bmask), 32'(model_bmask(t_memw, off, sz)));
                if (t_memw) check("wdata", dmem_wdata, model_wdata(t_r2, sz));
            end
            check("stall", 32'(stall), 32'(c < last));
            @(posedge clk);
            #1;
            if (c < last) begin
                check("bubble_ctl", 32'({o_rd_wren, o_insn_vld, o_mis, o_berr}), 32'h0);
                check("bubble_instr", o_instr, 32'h0);
                @(negedge clk);
            end else begin
                check("wb_pc", o_pc, t_pc);
                check("wb_instr", o_instr, t_instr);
                check("wb_rd", 32'(o_rd_addr), 32'(t_instr[11:7]));
                check("wb_vld", 32'(o_insn_vld), 32'(t_vld));
                check("wb_rdwren", 32'(o_rd_wren), 32'(t_rdw && !(mop && mis) && !tmo));
                check("wb_mis", 32'(o_mis), 32'(mop && mis));
                check("wb_berr", 32'(o_berr), 32'(tmo));
                if (t_sel == 2'b00)      exp_wb = t_pc + 32'd4;
                else if (t_sel == 2'b10) exp_wb = model_load(last_rdata, off, t_bn);
                else                     exp_wb = t_alu;
                if (!(t_sel == 2'b10 && (t_memw || mis || tmo)))
                    check("wb_data", o_wb_data, exp_wb);
            end
        end
        n_txn++;
        $display("txn %0d: pc=%h addr=%h bn=%0d sel=%0d st=%0d vld=%0d dly=%0d wb=%h mis=%0d berr=%0d",
                 n_txn, t_pc, t_alu, t_bn, t_sel, t_memw, t_vld, ack_delay,
                 o_wb_data, o_mis, o_berr);
    endtask

    logic [2:0] bn_tab [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

    initial begin
        rst_n = 1'b0;
        pc = '0; instr = '0; alu = '0; r2 = '0; pc4 = '0;
        rd_wren = 1'b0; mem_wren = 1'b0; insn_vld = 1'b0;
        wb_sel = 2'b00; byte_num = 3'b000;
        dmem_ack = 1'b0; dmem_rdata = '0;

        // Reset state
        #1;
        check("rst_req", 32'(dmem_req), 32'h0);
        check("rst_regs", 32'(|{o_pc, o_instr, o_wb_data, o_rd_addr,
                                 o_rd_wren, o_insn_vld, o_mis, o_berr}), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // SB to 0x1003, immediate ack
        run_insn(32'h100, 32'h0000_0023, 32'h0000_1003, 32'h0000_00A5,
                 1'b0, 1'b1, 1'b1, 2'b01, 3'b000, 0, 32'h0);
        // LH 0x2002, ack after 3 cycles
        run_insn(32'h104, 32'h0000_1283, 32'h0000_2002, 32'h0,
                 1'b1, 1'b0, 1'b1, 2'b10, 3'b001, 3, 32'h8001_0000);
        // LHU same address
        run_insn(32'h108, 32'h0000_5303, 32'h0000_2002, 32'h0,
                 1'b1, 1'b0, 1'b1, 2'b10, 3'b101, 3, 32'h8001_0000);
        // LW misaligned
        run_insn(32'h10C, 32'h0000_2383, 32'h0000_2001, 32'h0,
                 1'b1, 1'b0, 1'b1, 2'b10, 3'b010, 0, 32'h0);
        // LW, memory never answers
        run_insn(32'h110, 32'h0000_2403, 32'h0000_2000, 32'h0,
                 1'b1, 1'b0, 1'b1, 2'b10, 3'b010, -1, 32'h0);
        // Flushed bubble, then ADD
        run_insn(32'h0, 32'h0, 32'h0, 32'h0,
                 1'b0, 1'b0, 1'b0, 2'b10, 3'b000, 0, 32'h0);
        run_insn(32'h114, 32'h0000_04B3, 32'h0000_1234, 32'h0,
                 1'b1, 1'b0, 1'b1, 2'b01, 3'b010, 0, 32'h0);

        // Reset in the middle of a WAIT
        @(negedge clk);
        pc = 32'h118; instr = 32'h0000_2503; alu = 32'h0000_3000; pc4 = 32'h11C;
        rd_wren = 1'b1; mem_wren = 1'b0; insn_vld = 1'b1; wb_sel = 2'b10;
        byte_num = 3'b010; dmem_ack = 1'b0;
        #1;
        check("rw_req", 32'(dmem_req), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rw_req_drop", 32'(dmem_req), 32'h0);
        check("rw_stall", 32'(stall), 32'h0);
        check("rw_regs", 32'(|{o_pc, o_instr, o_wb_data, o_rd_addr,
                                o_rd_wren, o_insn_vld, o_mis, o_berr}), 32'h0);
        @(negedge clk);
        pc = '0; instr = '0; alu = '0; rd_wren = 1'b0; insn_vld = 1'b0; wb_sel = 2'b01;
        rst_n = 1'b1;
        #1;
        check("rw_idle_req", 32'(dmem_req), 32'h0);
        run_insn(32'h11C, 32'h0000_05B3, 32'h0000_5678, 32'h0,
                 1'b1, 1'b0, 1'b1, 2'b01, 3'b010, 0, 32'h0);

        // Random instruction mix
        for (int t = 0; t < 60; t++) begin
            run_insn($urandom(), $urandom(), $urandom(), $urandom(),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                     1'($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                     bn_tab[$urandom_range(0, 7)], int'($urandom_range(0, 5)), $urandom());
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
